// File: rtl/cpu_core_pkg.sv
// Shared encodings for cpu_core: FSM states, opcodes, instruction field layout and
// the mapping of core opcodes onto the 4-bit alu opcodes.
package cpu_core_pkg;

  typedef enum logic [3:0] {
    StReset,
    StFetch,
    StFetchW,
    StDecode,
    StExec,
    StMem,
    StMemW,
    StWb,
    StHalt
  } state_e;

  localparam int unsigned InstrW   = 32;
  localparam int unsigned OpW      = 4;
  localparam int unsigned RegAddrW = 4;
  localparam int unsigned ImmW     = 16;
  localparam int unsigned OpLsb    = 28;
  localparam int unsigned RdLsb    = 24;
  localparam int unsigned Rs1Lsb   = 20;
  localparam int unsigned Rs2Lsb   = 16;

  localparam logic [OpW-1:0] OpNop  = 4'h0;
  localparam logic [OpW-1:0] OpAdd  = 4'h1;
  localparam logic [OpW-1:0] OpSub  = 4'h2;
  localparam logic [OpW-1:0] OpAnd  = 4'h3;
  localparam logic [OpW-1:0] OpOr   = 4'h4;
  localparam logic [OpW-1:0] OpXor  = 4'h5;
  localparam logic [OpW-1:0] OpAddi = 4'h6;
  localparam logic [OpW-1:0] OpLd   = 4'h7;
  localparam logic [OpW-1:0] OpSt   = 4'h8;
  localparam logic [OpW-1:0] OpBeq  = 4'h9;
  localparam logic [OpW-1:0] OpJmp  = 4'hA;
  localparam logic [OpW-1:0] OpHlt  = 4'hF;

  localparam int unsigned AluOpW = 4;
  localparam logic [AluOpW-1:0] AluAdd = 4'h0;
  localparam logic [AluOpW-1:0] AluSub = 4'h1;
  localparam logic [AluOpW-1:0] AluAnd = 4'h2;
  localparam logic [AluOpW-1:0] AluOr  = 4'h3;
  localparam logic [AluOpW-1:0] AluXor = 4'h4;

  // BEQ compares via subtraction and the alu zero flag.
  function automatic logic [AluOpW-1:0] alu_op_map(input logic [OpW-1:0] op);
    case (op)
      OpSub, OpBeq: return AluSub;
      OpAnd:        return AluAnd;
      OpOr:         return AluOr;
      OpXor:        return AluXor;
      default:      return AluAdd;
    endcase
  endfunction

  function automatic logic op_legal(input logic [OpW-1:0] op);
    return (op <= OpJmp) || (op == OpHlt);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational integer alu with a 4-bit opcode and a zero flag on the result.
module alu
  import cpu_core_pkg::*;
#(
  parameter int unsigned WORD_W = 32
) (
  input  logic [AluOpW-1:0] op_i,
  input  logic [WORD_W-1:0] a_i,
  input  logic [WORD_W-1:0] b_i,
  output logic [WORD_W-1:0] y_o,
  output logic              zero_o
);

  always_comb begin
    y_o = '0;
    case (op_i)
      AluAdd:  y_o = a_i + b_i;
      AluSub:  y_o = a_i - b_i;
      AluAnd:  y_o = a_i & b_i;
      AluOr:   y_o = a_i | b_i;
      AluXor:  y_o = a_i ^ b_i;
      default: y_o = a_i + b_i;
    endcase
    zero_o = (y_o == '0);
  end

endmodule

// File: rtl/cpu_regfile.sv
// NREGS x WORD_W register file: two asynchronous read ports, one synchronous write
// port, r0 hardwired to zero.
module cpu_regfile
  import cpu_core_pkg::*;
#(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned NREGS  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [RegAddrW-1:0] raddr_a_i,
  input  logic [RegAddrW-1:0] raddr_b_i,
  output logic [WORD_W-1:0]   rdata_a_o,
  output logic [WORD_W-1:0]   rdata_b_o,
  input  logic                we_i,
  input  logic [RegAddrW-1:0] waddr_i,
  input  logic [WORD_W-1:0]   wdata_i
);

  localparam int unsigned IdxW = $clog2(NREGS);
  localparam logic [RegAddrW:0] NRegsL = NREGS[RegAddrW:0];

  logic [WORD_W-1:0] regs_q [NREGS];

  function automatic logic in_range(input logic [RegAddrW-1:0] a);
    return ({1'b0, a} < NRegsL) && (a != '0);
  endfunction

  always_comb begin
    rdata_a_o = in_range(raddr_a_i) ? regs_q[raddr_a_i[IdxW-1:0]] : '0;
    rdata_b_o = in_range(raddr_b_i) ? regs_q[raddr_b_i[IdxW-1:0]] : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
    end else if (we_i && in_range(waddr_i)) begin
      regs_q[waddr_i[IdxW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/cpu_core.sv
// Multi-cycle fetch/decode/execute core with a single req/ack memory port.
// Defining CPU_BUS_TIMEOUT_EN adds a bus watchdog that halts with err after BUS_TIMEOUT waits.
module cpu_core
  import cpu_core_pkg::*;
#(
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned NREGS       = 8,
  parameter int unsigned RESET_PC    = 0,
  parameter int unsigned BUS_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [WORD_W-1:0] mem_addr_o,
  output logic [WORD_W-1:0] mem_wdata_o,
  input  logic [WORD_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              halted_o,
  output logic              err_o,
  output logic [WORD_W-1:0] instret_o
);

  localparam logic [RegAddrW:0] NRegsL = NREGS[RegAddrW:0];

  state_e              state_q;
  logic [WORD_W-1:0]   pc_q, pc_next_q, a_q, b_q, res_q, instret_q;
  logic [WORD_W-1:0]   mem_addr_q, mem_wdata_q;
  logic [InstrW-1:0]   ir_q;
  logic                mem_req_q, mem_we_q, halted_q, err_q;

  logic [OpW-1:0]      op;
  logic [RegAddrW-1:0] rd, rs1, rs2;
  logic [WORD_W-1:0]   imm_sext, imm_zext, rf_rdata_a, rf_rdata_b, alu_b, alu_y;
  logic [AluOpW-1:0]   alu_op;
  logic                alu_zero, illegal, writes_rd, is_mem, rf_we, bus_expired;

  always_comb begin
    op        = ir_q[OpLsb +: OpW];
    rd        = ir_q[RdLsb +: RegAddrW];
    rs1       = ir_q[Rs1Lsb +: RegAddrW];
    rs2       = ir_q[Rs2Lsb +: RegAddrW];
    imm_sext  = {{(WORD_W-ImmW){ir_q[ImmW-1]}}, ir_q[ImmW-1:0]};
    imm_zext  = {{(WORD_W-ImmW){1'b0}}, ir_q[ImmW-1:0]};
    illegal   = !op_legal(op) || ({1'b0, rd} >= NRegsL) || ({1'b0, rs1} >= NRegsL) ||
                ({1'b0, rs2} >= NRegsL);
    writes_rd = (op >= OpAdd) && (op <= OpLd);
    is_mem    = (op == OpLd) || (op == OpSt);
    alu_op    = alu_op_map(op);
    alu_b     = ((op == OpAddi) || is_mem) ? imm_sext : b_q;
    rf_we     = (state_q == StWb) && writes_rd;
  end

  cpu_regfile #(
    .WORD_W (WORD_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .raddr_a_i (rs1),
    .raddr_b_i (rs2),
    .rdata_a_o (rf_rdata_a),
    .rdata_b_o (rf_rdata_b),
    .we_i      (rf_we),
    .waddr_i   (rd),
    .wdata_i   (res_q)
  );

  alu #(
    .WORD_W (WORD_W)
  ) u_alu (
    .op_i   (alu_op),
    .a_i    (a_q),
    .b_i    (alu_b),
    .y_o    (alu_y),
    .zero_o (alu_zero)
  );

`ifdef CPU_BUS_TIMEOUT_EN
  localparam int unsigned TimeoutW = $clog2(BUS_TIMEOUT + 1);
  logic [TimeoutW-1:0] wait_q;

  // Counts wait cycles of the current request; cleared whenever no request is pending.
  always_ff @(posedge clk) begin
    if (!rst || !(state_q inside {StFetchW, StMemW})) wait_q <= '0;
    else                                             wait_q <= wait_q + 1'b1;
  end

  assign bus_expired = (state_q inside {StFetchW, StMemW}) &&
                       (wait_q == TimeoutW'(BUS_TIMEOUT - 1));
`else
  assign bus_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StReset;
      pc_q        <= WORD_W'(RESET_PC);
      pc_next_q   <= '0;
      ir_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      instret_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      halted_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        StReset: state_q <= StFetch;
        StFetch: begin
          mem_req_q  <= 1'b1;
          mem_we_q   <= 1'b0;
          mem_addr_q <= pc_q;
          state_q    <= StFetchW;
        end
        StFetchW: begin
          if (mem_ack_i) begin
            ir_q      <= InstrW'(mem_rdata_i);
            mem_req_q <= 1'b0;
            state_q   <= StDecode;
          end else if (bus_expired) begin
            mem_req_q <= 1'b0;
            err_q     <= 1'b1;
            halted_q  <= 1'b1;
            state_q   <= StHalt;
          end
        end
        StDecode: begin
          a_q     <= rf_rdata_a;
          b_q     <= rf_rdata_b;
          state_q <= StExec;
        end
        StExec: begin
          res_q     <= alu_y;
          pc_next_q <= pc_q + WORD_W'(1);
          if (illegal) begin
            err_q    <= 1'b1;
            halted_q <= 1'b1;
            state_q  <= StHalt;
          end else if (op == OpHlt) begin
            instret_q <= instret_q + WORD_W'(1);
            halted_q  <= 1'b1;
            state_q   <= StHalt;
          end else if (is_mem) begin
            state_q <= StMem;
          end else begin
            state_q <= StWb;
            if ((op == OpBeq) && alu_zero) pc_next_q <= pc_q + WORD_W'(1) + imm_sext;
            else if (op == OpJmp)          pc_next_q <= imm_zext;
          end
        end
        StMem: begin
          mem_req_q   <= 1'b1;
          mem_we_q    <= (op == OpSt);
          mem_addr_q  <= res_q;
          mem_wdata_q <= b_q;
          state_q     <= StMemW;
        end
        StMemW: begin
          if (mem_ack_i) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (op == OpLd) res_q <= mem_rdata_i;
            state_q   <= StWb;
          end else if (bus_expired) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            err_q     <= 1'b1;
            halted_q  <= 1'b1;
            state_q   <= StHalt;
          end
        end
        StWb: begin
          pc_q      <= pc_next_q;
          instret_q <= instret_q + WORD_W'(1);
          state_q   <= StFetch;
        end
        StHalt:  state_q <= StHalt;
        default: state_q <= StHalt;
      endcase
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign halted_o    = halted_q;
  assign err_o       = err_q;
  assign instret_o   = instret_q;

endmodule

// File: tb/tb_cpu_core.sv
// Bench for cpu_core: an instruction-level model predicts every bus transaction and the
// final status; a bus responder with random ack delays checks each request against it.
module tb_cpu_core;

  localparam int unsigned Tmo = 4;
`ifdef CPU_BUS_TIMEOUT_EN
  localparam int MaxWait = 3;
`else
  localparam int MaxWait = 4;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req_o, mem_we_o, mem_ack_i, halted_o, err_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i, instret_o;

  always #5 clk = ~clk;

  cpu_core #(
    .WORD_W      (32),
    .NREGS       (8),
    .RESET_PC    (0),
    .BUS_TIMEOUT (Tmo)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i),
    .halted_o    (halted_o),
    .err_o       (err_o),
    .instret_o   (instret_o)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] bmem [256];
  logic [31:0] mmem [256];
  logic [31:0] prog [$];
  txn_t        expq [$];
  int          exp_instret;
  bit          exp_halt, exp_err, stopped;
  logic [31:0] saved;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_prog();
    for (int i = 0; i < 256; i++) bmem[i] = $urandom;
    for (int i = 0; i < prog.size(); i++) bmem[i] = prog[i];
    mmem = bmem;
  endtask

  // Architectural model: executes from mmem, records expected bus traffic.
  task automatic run_model(input int max_steps);
    logic [31:0] r [8];
    logic [31:0] pc, ins, imm, val, a, npc;
    int op, rd, rs1, rs2;
    bit wr;
    for (int i = 0; i < 8; i++) r[i] = 0;
    pc = 0; expq.delete(); exp_instret = 0; exp_halt = 0; exp_err = 0;
    for (int s = 0; s < max_steps && !exp_halt; s++) begin
      ins = mmem[pc[7:0]];
      expq.push_back('{1'b0, pc, 32'h0});
      op = int'(ins[31:28]); rd = int'(ins[27:24]); rs1 = int'(ins[23:20]); rs2 = int'(ins[19:16]);
      imm = {{16{ins[15]}}, ins[15:0]};
      if (rd >= 8 || rs1 >= 8 || rs2 >= 8 || (op >= 11 && op <= 14)) begin
        exp_err = 1; exp_halt = 1;
      end else begin
        npc = pc + 1; wr = 1; val = 0;
        case (op)
          1: val = r[rs1] + r[rs2];
          2: val = r[rs1] - r[rs2];
          3: val = r[rs1] & r[rs2];
          4: val = r[rs1] | r[rs2];
          5: val = r[rs1] ^ r[rs2];
          6: val = r[rs1] + imm;
          7: begin
            a = r[rs1] + imm; expq.push_back('{1'b0, a, 32'h0}); val = mmem[a[7:0]];
          end
          8: begin
            wr = 0; a = r[rs1] + imm; expq.push_back('{1'b1, a, r[rs2]}); mmem[a[7:0]] = r[rs2];
          end
          9: begin wr = 0; if (r[rs1] == r[rs2]) npc = pc + 1 + imm; end
          10: begin wr = 0; npc = {16'h0, ins[15:0]}; end
          15: begin wr = 0; exp_halt = 1; end
          default: wr = 0;
        endcase
        if (wr && rd != 0) r[rd] = val;
        exp_instret++;
        pc = npc;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b0; mem_ack_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Bus responder: matches each request with the model's queue, holds it for a wait, acks.
  task automatic serve(input int max_wait, input int fixed_wait, input bit stop_at_write,
                       output bit stop_o);
    bit busy = 0, just_acked = 0, done = 0;
    int wl = 0;
    txn_t e, snap;
    stop_o = 0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      mem_ack_i = 1'b0;
      if (just_acked) begin check("req_drop", 32'(mem_req_o), 0); just_acked = 0; end
      if (expq.size() == 0 && !busy && (exp_halt ? halted_o : 1'b1)) begin done = 1; break; end
      if (mem_req_o && !busy) begin
        if (expq.size() == 0) begin check("extra_req", 32'(mem_req_o), 0); done = 1; break; end
        e = expq.pop_front();
        check("req_we", 32'(mem_we_o), 32'(e.we));
        check("req_addr", mem_addr_o, e.addr);
        if (e.we) check("req_wdata", mem_wdata_o, e.wdata);
        snap = '{mem_we_o, mem_addr_o, mem_wdata_o};
        busy = 1;
        wl = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(max_wait, 0));
        if (stop_at_write && e.we) begin stop_o = 1; return; end
      end else if (busy) begin
        check("hold_req", 32'(mem_req_o), 1);
        check("hold_addr", mem_addr_o, snap.addr);
        check("hold_we", 32'(mem_we_o), 32'(snap.we));
      end
      if (busy) begin
        if (wl == 0) begin
          mem_ack_i = 1'b1;
          mem_rdata_i = bmem[mem_addr_o[7:0]];
          if (mem_we_o) bmem[mem_addr_o[7:0]] = mem_wdata_o;
          busy = 0; just_acked = 1;
        end else wl--;
      end
    end
    check("serve_done", 32'(done), 1);
  endtask

  task automatic final_checks();
    check("halted", 32'(halted_o), 32'(exp_halt));
    check("err", 32'(err_o), 32'(exp_err));
    if (exp_halt) check("instret", instret_o, 32'(exp_instret));
  endtask

  task automatic run_prog(input int max_wait, input int fixed_wait, input int steps);
    load_prog(); run_model(steps); do_reset();
    serve(max_wait, fixed_wait, 1'b0, stopped);
    final_checks();
  endtask

  task automatic gen_random();
    int op, rd, rs1, rs2, imm;
    prog.delete();
    for (int i = 0; i < 30; i++) begin
      op = $urandom_range(9, 0); rd = $urandom_range(7, 0);
      rs1 = $urandom_range(7, 0); rs2 = $urandom_range(7, 0); imm = $urandom;
      if (op == 7 || op == 8) begin
        imm = $urandom_range(255, 64);
        if ($urandom_range(1, 0) == 0) rs1 = 0;
      end
      if (op == 9) imm = $urandom_range(3, 0);
      prog.push_back({4'(op), 4'(rd), 4'(rs1), 4'(rs2), 16'(imm)});
    end
    for (int r = 1; r < 8; r++) prog.push_back({4'h8, 4'h0, 4'h0, 4'(r), 16'(128 + r)});
    prog.push_back(32'hF000_0000);
  endtask

  initial begin
    mem_ack_i = 1'b0; mem_rdata_i = '0; rst = 1'b0;

    // Reset held with a stray ack, then the sum/store program from RESET_PC.
    prog = '{32'h6100_0005, 32'h6200_FFFD, 32'h1312_0000, 32'h8003_0010, 32'hF000_0000};
    load_prog(); run_model(50);
    @(negedge clk); mem_ack_i = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req", 32'(mem_req_o), 0);
    check("rst_we", 32'(mem_we_o), 0);
    check("rst_addr", mem_addr_o, 0);
    check("rst_wdata", mem_wdata_o, 0);
    check("rst_halted", 32'(halted_o), 0);
    check("rst_err", 32'(err_o), 0);
    check("rst_instret", instret_o, 0);
    mem_ack_i = 1'b0; rst = 1'b1;
    serve(MaxWait, -1, 1'b0, stopped);
    final_checks();
    check("sum_store", bmem[16], 32'd2);
    check("sum_instret", instret_o, 32'd5);

    // Load with a long ack wait.
    prog = '{32'h6100_0064, 32'h7210_0004, 32'h8002_0014, 32'hF000_0000};
    load_prog(); saved = bmem[104]; run_model(50); do_reset();
    serve(0, MaxWait, 1'b0, stopped);
    final_checks();
    check("ld_value", bmem[20], saved);

    // Wrapping add and a not-taken branch at pc 7.
    prog = '{32'h6100_0001, 32'h6400_FFFF, 32'h1444_0000, 32'h8004_001E, 32'h0, 32'h0, 32'h0,
             32'h9012_FFFF, 32'hF000_0000};
    run_prog(MaxWait, -1, 50);
    check("wrap_add", bmem[30], 32'hFFFF_FFFE);

    // Taken self-branch at pc 7 spins on fetches of address 7.
    prog = '{32'h6100_0001, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h9011_FFFF};
    run_prog(MaxWait, -1, 12);

    // Illegal opcode, then out-of-range rd; late acks while halted are ignored.
    prog = '{32'h6100_0007, 32'hC110_0000, 32'h8001_0010};
    run_prog(MaxWait, -1, 50);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); mem_ack_i = 1'b1; mem_rdata_i = $urandom;
      check("halt_no_req", 32'(mem_req_o), 0);
    end
    mem_ack_i = 1'b0;
    check("halt_instret", instret_o, 32'd1);
    prog = '{32'h6900_0005, 32'h8009_0010};
    run_prog(MaxWait, -1, 50);

    // Reset while a store waits for ack; restart from RESET_PC.
    prog = '{32'h6100_0003, 32'h8001_0028, 32'hF000_0000};
    load_prog(); run_model(50); do_reset();
    serve(MaxWait, -1, 1'b1, stopped);
    check("stopped_at_store", 32'(stopped), 1);
    rst = 1'b0; mem_ack_i = 1'b1;
    @(negedge clk);
    check("rst_mid_req", 32'(mem_req_o), 0);
    check("rst_mid_we", 32'(mem_we_o), 0);
    rst = 1'b1; mem_ack_i = 1'b0;
    run_model(50);
    serve(MaxWait, -1, 1'b0, stopped);
    final_checks();
    check("restart_store", bmem[40], 32'd3);

`ifdef CPU_BUS_TIMEOUT_EN
    begin
      int hi = 0;
      prog = '{32'hF000_0000};
      load_prog(); do_reset();
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (mem_req_o) hi++;
        else if (hi > 0) break;
      end
      check("tmo_cycles", 32'(hi), 32'(Tmo));
      check("tmo_err", 32'(err_o), 1);
      check("tmo_halted", 32'(halted_o), 1);
    end
`endif

    for (int n = 0; n < 8; n++) begin
      gen_random();
      run_prog(MaxWait, -1, 400);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
